// File: rtl/ram_sdp_clr_if.sv
// Port bundle for ram_sdp_clr: clear handshake, write port and read port.
// Ports: clr_req/busy (clear), wr_en/wr_be/wr_addr/wr_data (write),
//        rd_en/rd_addr/rd_data/rd_valid (read), par_err when RAM_PARITY_EN is defined.
interface ram_sdp_clr_if #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH_LOG2 = 9
);
   localparam int NBYTES = DATA_WIDTH / 8;

   logic                  clr_req;
   logic                  busy;
   logic                  wr_en;
   logic [NBYTES-1:0]     wr_be;
   logic [DEPTH_LOG2-1:0] wr_addr;
   logic [DATA_WIDTH-1:0] wr_data;
   logic                  rd_en;
   logic [DEPTH_LOG2-1:0] rd_addr;
   logic [DATA_WIDTH-1:0] rd_data;
   logic                  rd_valid;
`ifdef RAM_PARITY_EN
   logic                  par_err;

   modport master (
      output clr_req, wr_en, wr_be, wr_addr, wr_data, rd_en, rd_addr,
      input  busy, rd_data, rd_valid, par_err
   );
   modport slave (
      input  clr_req, wr_en, wr_be, wr_addr, wr_data, rd_en, rd_addr,
      output busy, rd_data, rd_valid, par_err
   );
`else
   modport master (
      output clr_req, wr_en, wr_be, wr_addr, wr_data, rd_en, rd_addr,
      input  busy, rd_data, rd_valid
   );
   modport slave (
      input  clr_req, wr_en, wr_be, wr_addr, wr_data, rd_en, rd_addr,
      output busy, rd_data, rd_valid
   );
`endif
endinterface

// File: rtl/ram_sdp_clr.sv
// Simple-dual-port RAM with byte-lane writes, selectable collision mode and self-clear sweep.
// Latency: read data 1 cycle after rd_en (OUT_REG=0) or 2 cycles (OUT_REG=1); clear sweep DEPTH cycles.
// Backpressure: none on reads/writes; while busy=1 all wr_en/rd_en/clr_req are dropped.
// Ports: i_clk, i_rst_n (async active-low), bus (ram_sdp_clr_if.slave).
// Optional feature macro: RAM_PARITY_EN adds one even-parity bit per byte lane and bus.par_err.
module ram_sdp_clr #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH_LOG2 = 9,
   parameter int RD_MODE    = 0,   // 0 = read-first, 1 = write-first on same-address collision
   parameter int OUT_REG    = 1    // 1 = extra output register stage
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   ram_sdp_clr_if.slave bus
);
   localparam int NBYTES = DATA_WIDTH / 8;
   localparam int DEPTH  = 1 << DEPTH_LOG2;
`ifdef RAM_PARITY_EN
   localparam int MW = DATA_WIDTH + NBYTES;   // parity bits sit above the data bits
`else
   localparam int MW = DATA_WIDTH;
`endif

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [DEPTH_LOG2-1:0] r_cnt;
   logic                  w_busy;
   logic                  w_clr_wr;
   logic                  w_cnt_last;
   logic                  w_wr_acc;
   logic                  w_rd_acc;
   logic                  w_coll;

   logic [MW-1:0]         r_mem [DEPTH];
   logic [MW-1:0]         w_rd_old;
   logic [MW-1:0]         w_rd_word;

   logic                  r_s1_vld;
   logic [MW-1:0]         r_s1_word;
   logic                  w_out_vld;
   logic [MW-1:0]         w_out_word;

   // ------------------------------------------------------------------
   // Clear FSM: state register / next state / outputs
   // ------------------------------------------------------------------
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= ST_CLEAR;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   assign w_cnt_last = &r_cnt;

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_CLEAR: if (w_cnt_last)  w_state_nxt = ST_IDLE;
         ST_IDLE:  if (bus.clr_req) w_state_nxt = ST_CLEAR;
         default:                   w_state_nxt = ST_CLEAR;
      endcase
   end

   always_comb begin
      w_busy   = 1'b0;
      w_clr_wr = 1'b0;
      if (r_state == ST_CLEAR) begin
         w_busy   = 1'b1;
         w_clr_wr = 1'b1;
      end
   end

   // Sweep address. It wraps to 0 after the last word, so it is already
   // zero on IDLE entry; the explicit load on clr_req keeps that obvious.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt <= '0;
      end else if (r_state == ST_CLEAR) begin
         r_cnt <= r_cnt + 1'b1;
      end else if (bus.clr_req) begin
         r_cnt <= '0;
      end
   end

   assign bus.busy = w_busy;

   // ------------------------------------------------------------------
   // Port acceptance
   // ------------------------------------------------------------------
   assign w_wr_acc = bus.wr_en & ~w_busy;
   assign w_rd_acc = bus.rd_en & ~w_busy;
   assign w_coll   = w_wr_acc & (bus.wr_addr == bus.rd_addr);

   // ------------------------------------------------------------------
   // Storage: no reset on the array; the sweep zeroes it instead.
   // Reads are blocked during the sweep, so sweep writes never collide.
   // ------------------------------------------------------------------
   always_ff @(posedge i_clk) begin
      if (w_clr_wr) begin
         r_mem[r_cnt] <= '0;
      end else if (w_wr_acc) begin
         for (int i = 0; i < NBYTES; i++) begin
            if (bus.wr_be[i]) begin
               r_mem[bus.wr_addr][8*i +: 8] <= bus.wr_data[8*i +: 8];
`ifdef RAM_PARITY_EN
               r_mem[bus.wr_addr][DATA_WIDTH+i] <= ^bus.wr_data[8*i +: 8];
`endif
            end
         end
      end
   end

   assign w_rd_old = r_mem[bus.rd_addr];

   // Write-first mode forwards the enabled lanes of the concurrent write;
   // read-first mode simply returns the array contents before the edge.
   always_comb begin
      w_rd_word = w_rd_old;
      if ((RD_MODE != 0) && w_coll) begin
         for (int i = 0; i < NBYTES; i++) begin
            if (bus.wr_be[i]) begin
               w_rd_word[8*i +: 8] = bus.wr_data[8*i +: 8];
`ifdef RAM_PARITY_EN
               w_rd_word[DATA_WIDTH+i] = ^bus.wr_data[8*i +: 8];
`endif
            end
         end
      end
   end

   // ------------------------------------------------------------------
   // Read pipeline. Data registers only load on a valid so rd_data holds.
   // ------------------------------------------------------------------
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_s1_vld  <= 1'b0;
         r_s1_word <= '0;
      end else begin
         r_s1_vld <= w_rd_acc;
         if (w_rd_acc) begin
            r_s1_word <= w_rd_word;
         end
      end
   end

   if (OUT_REG != 0) begin : g_oreg
      logic          r_s2_vld;
      logic [MW-1:0] r_s2_word;

      always_ff @(posedge i_clk or negedge i_rst_n) begin
         if (!i_rst_n) begin
            r_s2_vld  <= 1'b0;
            r_s2_word <= '0;
         end else begin
            r_s2_vld <= r_s1_vld;
            if (r_s1_vld) begin
               r_s2_word <= r_s1_word;
            end
         end
      end

      assign w_out_vld  = r_s2_vld;
      assign w_out_word = r_s2_word;
   end else begin : g_noreg
      assign w_out_vld  = r_s1_vld;
      assign w_out_word = r_s1_word;
   end

   assign bus.rd_valid = w_out_vld;
   assign bus.rd_data  = w_out_word[DATA_WIDTH-1:0];

`ifdef RAM_PARITY_EN
   // Parity is rechecked on the word actually presented, so par_err lines
   // up with rd_valid whatever the pipeline depth.
   logic [NBYTES-1:0] w_par_calc;

   always_comb begin
      w_par_calc = '0;
      for (int i = 0; i < NBYTES; i++) begin
         w_par_calc[i] = ^w_out_word[8*i +: 8];
      end
   end

   assign bus.par_err = w_out_vld & (|(w_par_calc ^ w_out_word[MW-1:DATA_WIDTH]));
`endif

endmodule

// File: tb/tb_ram_sdp_clr.sv
`timescale 1ns/1ps
module tb_ram_sdp_clr;
   localparam int DW      = 32;
   localparam int AW      = 6;
   localparam int DEPTH   = 1 << AW;
   localparam int RD_MODE = 0;
   localparam int OUT_REG = 1;
   localparam int LAT     = (OUT_REG != 0) ? 2 : 1;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_chk = 0;
   int   n_err = 0;
   logic last_perr;

   ram_sdp_clr_if #(.DATA_WIDTH(DW), .DEPTH_LOG2(AW)) rif ();

   ram_sdp_clr #(
      .DATA_WIDTH (DW),
      .DEPTH_LOG2 (AW),
      .RD_MODE    (RD_MODE),
      .OUT_REG    (OUT_REG)
   ) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (rif)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Read (optionally with a same-cycle write), check exact latency, data, pulse width and hold.
   task automatic do_rw(input string tag, input logic [AW-1:0] raddr, input logic [DW-1:0] exp,
                        input bit wr, input logic [AW-1:0] waddr, input logic [3:0] wbe,
                        input logic [DW-1:0] wdata);
      rif.rd_en   = 1'b1;
      rif.rd_addr = raddr;
      rif.wr_en   = wr;
      rif.wr_addr = waddr;
      rif.wr_be   = wbe;
      rif.wr_data = wdata;
      for (int c = 1; c <= LAT; c++) begin
         step();
         rif.rd_en = 1'b0;
         rif.wr_en = 1'b0;
         check({tag, " vld@", $sformatf("%0d", c)}, rif.rd_valid, (c == LAT) ? 1 : 0);
      end
      check({tag, " dat"}, rif.rd_data, exp);
`ifdef RAM_PARITY_EN
      last_perr = rif.par_err;
`else
      last_perr = 1'b0;
`endif
      step();
      check({tag, " vld drop"}, rif.rd_valid, 0);
      check({tag, " hold"}, rif.rd_data, exp);
   endtask

   task automatic do_read(input string tag, input logic [AW-1:0] raddr, input logic [DW-1:0] exp);
      do_rw(tag, raddr, exp, 1'b0, '0, 4'h0, '0);
   endtask

   task automatic do_write(input logic [AW-1:0] addr, input logic [3:0] be, input logic [DW-1:0] data);
      rif.wr_en   = 1'b1;
      rif.wr_addr = addr;
      rif.wr_be   = be;
      rif.wr_data = data;
      step();
      rif.wr_en = 1'b0;
   endtask

   // Count samples with busy=1; poke drives traffic (and a stray clr_req) that must be ignored.
   task automatic count_busy(input bit poke, output int n, output int nv, output logic [DW-1:0] ld);
      n  = 0;
      nv = 0;
      ld = '0;
      while (rif.busy === 1'b1 && n < 4 * DEPTH) begin
         n++;
         if (rif.rd_valid === 1'b1) begin
            nv++;
            ld = rif.rd_data;
         end
         if (poke) begin
            rif.wr_en   = 1'b1;
            rif.wr_addr = 6'd3;
            rif.wr_be   = 4'hF;
            rif.wr_data = 32'hCAFE_F00D;
            rif.rd_en   = 1'b1;
            rif.rd_addr = 6'd3;
            rif.clr_req = (n == 3);
         end
         step();
      end
      rif.clr_req = 1'b0;
      if (poke) begin
         rif.wr_en = 1'b0;
         rif.rd_en = 1'b0;
      end
   endtask

   logic [AW-1:0] b2b_addr [3];
   logic [DW-1:0] b2b_exp  [3];

   initial begin
      int            n;
      int            nv;
      logic [DW-1:0] ld;
      int            j;

      rif.clr_req = 1'b0;
      rif.wr_en   = 1'b0;
      rif.wr_be   = '0;
      rif.wr_addr = '0;
      rif.wr_data = '0;
      rif.rd_en   = 1'b1;
      rif.rd_addr = 6'd5;
      last_perr   = 1'b0;

      // 1: reset state, then a DEPTH-cycle sweep with rd_en held and ignored
      #12;
      check("rst busy", rif.busy, 1);
      check("rst rd_valid", rif.rd_valid, 0);
      check("rst rd_data", rif.rd_data, 0);
      rst_n = 1'b1;
      count_busy(1'b0, n, nv, ld);
      rif.rd_en = 1'b0;
      check("t1 busy cycles", n, DEPTH);
      check("t1 no rd_valid while busy", nv, 0);
      do_read("t1 a5", 6'd5, 32'h0);

      // 2: full-word write and read
      do_write(6'h10, 4'hF, 32'hDEAD_BEEF);
      do_read("t2 a10", 6'h10, 32'hDEAD_BEEF);

      // 3: byte lanes, then wr_be=0 is a no-op
      do_write(6'h20, 4'hF, 32'h1122_3344);
      do_write(6'h20, 4'b0101, 32'hAABB_CCDD);
      do_read("t3 be0101", 6'h20, 32'h11BB_33DD);
      do_write(6'h20, 4'h0, 32'hFFFF_FFFF);
      do_read("t3 be0", 6'h20, 32'h11BB_33DD);

      // 4: same-address collision
      do_write(6'd7, 4'hF, 32'h1);
      do_rw("t4 coll", 6'd7, (RD_MODE != 0) ? 32'h2 : 32'h1, 1'b1, 6'd7, 4'hF, 32'h2);
      do_read("t4 after", 6'd7, 32'h2);

      // back-to-back reads, one word per cycle
      b2b_addr[0] = 6'h10; b2b_exp[0] = 32'hDEAD_BEEF;
      b2b_addr[1] = 6'h20; b2b_exp[1] = 32'h11BB_33DD;
      b2b_addr[2] = 6'd7;  b2b_exp[2] = 32'h2;
      for (int c = 0; c < 3 + LAT; c++) begin
         rif.rd_en = (c < 3);
         if (c < 3) rif.rd_addr = b2b_addr[c];
         step();
         j = c + 1 - LAT;
         check($sformatf("b2b vld c%0d", c), rif.rd_valid, (j >= 0 && j < 3) ? 1 : 0);
         if (j >= 0 && j < 3) check($sformatf("b2b dat %0d", j), rif.rd_data, b2b_exp[j]);
      end
      rif.rd_en = 1'b0;

`ifdef RAM_PARITY_EN
      // 6: parity error on a corrupted stored bit
      do_write(6'd9, 4'hF, 32'h0F0F_0F01);
      do_read("t6 clean", 6'd9, 32'h0F0F_0F01);
      check("t6 par_err clean", last_perr, 0);
      dut.r_mem[9][0] = ~dut.r_mem[9][0];
      do_read("t6 flip", 6'd9, 32'h0F0F_0F00);
      check("t6 par_err flip", last_perr, 1);
`endif

      // clr_req with write and read in the same cycle; traffic during busy ignored
      check("pre-clr busy", rif.busy, 0);
      rif.clr_req = 1'b1;
      rif.wr_en   = 1'b1; rif.wr_addr = 6'h10; rif.wr_be = 4'hF; rif.wr_data = 32'h55;
      rif.rd_en   = 1'b1; rif.rd_addr = 6'h20;
      step();
      rif.clr_req = 1'b0;
      rif.wr_en   = 1'b0;
      rif.rd_en   = 1'b0;
      count_busy(1'b1, n, nv, ld);
      check("clr busy cycles", n, DEPTH);
      check("clr in-flight reads", nv, 1);
      check("clr in-flight data", ld, 32'h11BB_33DD);
      do_read("clr a10", 6'h10, 32'h0);
      do_read("clr a20", 6'h20, 32'h0);
      do_read("clr a3", 6'd3, 32'h0);

      // 5: fill, clear, reset mid-sweep with a read in flight
      for (int a = 0; a < 4; a++) do_write(AW'(a), 4'hF, 32'hA5A5_0000 + DW'(a));
      do_read("t5 fill a2", 6'd2, 32'hA5A5_0002);
      rif.clr_req = 1'b1;
      rif.rd_en   = 1'b1; rif.rd_addr = 6'd1;
      step();
      rif.clr_req = 1'b0;
      rif.rd_en   = 1'b0;
      step();
      rst_n = 1'b0;
      #1;
      check("t5 rst busy", rif.busy, 1);
      check("t5 rst rd_valid", rif.rd_valid, 0);
      check("t5 rst rd_data", rif.rd_data, 0);
      step();
      check("t5 rst hold vld", rif.rd_valid, 0);
      rst_n = 1'b1;
      count_busy(1'b0, n, nv, ld);
      check("t5 busy cycles", n, DEPTH);
      check("t5 no rd_valid", nv, 0);
      for (int a = 0; a < 4; a++) do_read($sformatf("t5 a%0d", a), AW'(a), 32'h0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end
endmodule
